cc1200_spi_master: RTL and testbench

//  SPI master (mode 0, MSB first) producing SCLK_0/MOSI_0/CS_n_0 and sampling MISO_0 for the CC1200.

---
 rtl/cc1200_spi_master.sv | 200 ++++++++++++++++++++
 tb/tb_cc1200_spi_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc1200_spi_master.sv
// rtl/cc1200_spi_master.sv - SPI mode-0 master sequencing CC1200 header, extended-address and data byte slots
module cc1200_spi_master #(
  parameter int CLK_DIV       = 4,
  parameter int CS_SETUP      = 2,
  parameter int CS_HOLD       = 2,
  parameter int READY_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] header,
  input  logic       ext_en,
  input  logic [7:0] ext_addr,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] status_byte,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       SCLK_0,
  output logic       MOSI_0,
  input  logic       MISO_0,
  output logic       CS_n_0
);

  localparam int CNT_MAX = (READY_TIMEOUT > CS_SETUP)
                         ? ((READY_TIMEOUT > CS_HOLD) ? READY_TIMEOUT : CS_HOLD)
                         : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] RDY_LAST   = CW'(READY_TIMEOUT - 1);
  localparam logic [CW-1:0] RDY_MIN    = CW'(2);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SETUP, S_SHIFT, S_NEXT_BYTE, S_HOLD, S_DONE
  } state_t;

  typedef enum logic [1:0] {SLOT_HDR, SLOT_EXT, SLOT_DATA} slot_t;

  state_t        state_q, state_d;
  slot_t         slot_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic          rd_q;
  logic          ext_pend_q;
  logic [7:0]    ext_q;
  logic [7:0]    bytes_left_q;
  logic [7:0]    tx_shift_q;
  logic [7:0]    rx_shift_q;
  logic          miso_s1, miso_s2;
  logic          half_end, byte_end, nb_go;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    half_end = (div_q == DIV_LAST);
    byte_end = 1'b0;
    nb_go    = 1'b0;
    tx_ready = 1'b0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_RDY;
      // Only trust the synchroniser once it has refilled since CS_n fell.
      S_WAIT_RDY: begin
        if (cnt_q >= RDY_MIN && !miso_s2) state_d = S_SETUP;
        else if (cnt_q == RDY_LAST)       state_d = S_HOLD;
      end
      S_SETUP:     if (cnt_q == SETUP_LAST) state_d = S_SHIFT;
      S_SHIFT: begin
        if (half_end && SCLK_0 && bit_q == 3'd7) begin
          byte_end = 1'b1;
          state_d  = (ext_pend_q || bytes_left_q != 8'd0) ? S_NEXT_BYTE : S_HOLD;
        end
      end
      // This state doubles as the first low clk of the next byte's bit 7.
      S_NEXT_BYTE: begin
        nb_go    = ext_pend_q || rd_q || tx_valid;
        tx_ready = nb_go && !ext_pend_q && !rd_q;
        if (nb_go) state_d = S_SHIFT;
      end
      S_HOLD:      if (cnt_q == HOLD_LAST) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1      <= 1'b1;
      miso_s2      <= 1'b1;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= 3'd0;
      slot_q       <= SLOT_HDR;
      rd_q         <= 1'b0;
      ext_pend_q   <= 1'b0;
      ext_q        <= 8'h00;
      bytes_left_q <= 8'h00;
      tx_shift_q   <= 8'h00;
      rx_shift_q   <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      status_byte  <= 8'h00;
      timeout_err  <= 1'b0;
      SCLK_0       <= 1'b0;
      MOSI_0       <= 1'b0;
      CS_n_0       <= 1'b1;
    end else begin
      miso_s1  <= MISO_0;
      miso_s2  <= miso_s1;
      rx_valid <= 1'b0;
      CS_n_0   <= (state_d == S_IDLE) || (state_d == S_DONE);
      cnt_q    <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_q         <= header[7];
            ext_pend_q   <= ext_en;
            ext_q        <= ext_addr;
            bytes_left_q <= len;
            tx_shift_q   <= header;
            MOSI_0       <= header[7];
            timeout_err  <= 1'b0;
          end
        end
        S_WAIT_RDY: if (state_d == S_HOLD) timeout_err <= 1'b1;
        S_SETUP: begin
          if (state_d == S_SHIFT) begin
            div_q  <= '0;
            bit_q  <= 3'd0;
            slot_q <= SLOT_HDR;
          end
        end
        S_SHIFT: begin
          if (half_end) begin
            div_q <= '0;
            if (!SCLK_0) begin
              SCLK_0     <= 1'b1;
              rx_shift_q <= {rx_shift_q[6:0], miso_s2};
            end else begin
              SCLK_0 <= 1'b0;
              if (byte_end) begin
                bit_q <= 3'd0;
                case (slot_q)
                  SLOT_HDR:  status_byte <= rx_shift_q;
                  SLOT_DATA: begin
                    rx_data  <= rx_shift_q;
                    rx_valid <= 1'b1;
                  end
                  default: ;
                endcase
              end else begin
                bit_q      <= bit_q + 3'd1;
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                MOSI_0     <= tx_shift_q[6];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_NEXT_BYTE: begin
          if (nb_go) begin
            div_q <= DIV_ONE;
            if (ext_pend_q) begin
              ext_pend_q <= 1'b0;
              slot_q     <= SLOT_EXT;
              tx_shift_q <= ext_q;
              MOSI_0     <= ext_q[7];
            end else begin
              bytes_left_q <= bytes_left_q - 8'd1;
              slot_q       <= SLOT_DATA;
              tx_shift_q   <= rd_q ? 8'h00 : tx_data;
              MOSI_0       <= !rd_q && tx_data[7];
            end
          end
        end
        S_DONE:  MOSI_0 <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cc1200_spi_master.sv
// tb/tb_cc1200_spi_master.sv - directed self-checking bench for cc1200_spi_master with a behavioural CC1200 slave
module tb_cc1200_spi_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic [7:0] header = 8'h00;
  logic       ext_en = 1'b0;
  logic [7:0] ext_addr = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] status_byte;
  logic       busy, done, timeout_err;
  logic       SCLK_0, MOSI_0, MISO_0, CS_n_0;

  always #5 clk = ~clk;

  cc1200_spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .READY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .header(header), .ext_en(ext_en),
    .ext_addr(ext_addr), .len(len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .status_byte(status_byte), .busy(busy), .done(done), .timeout_err(timeout_err),
    .SCLK_0(SCLK_0), .MOSI_0(MOSI_0), .MISO_0(MISO_0), .CS_n_0(CS_n_0)
  );

  int errors = 0;
  int checks = 0;

  // Slave model: status byte out on CS fall, shifts on SCLK fall, captures MOSI on SCLK rise.
  logic [7:0] resp [0:7];
  logic [7:0] mosi_log [0:15];
  logic [7:0] rx_log [0:15];
  logic [7:0] slave_sr = 8'hFF;
  logic [7:0] mosi_sr = 8'h00;
  logic       miso_force_high = 1'b0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  int resp_idx = 0, fbits = 0, rbits = 0, mosi_n = 0;
  int sclk_rises = 0, txr_cnt = 0, done_cnt = 0, rx_n = 0, cs_rise_cnt = 0;

  assign MISO_0 = miso_force_high ? 1'b1 : (CS_n_0 ? 1'b1 : slave_sr[7]);

  always @(negedge clk) begin
    if (!prev_sclk && SCLK_0) sclk_rises++;
    if (tx_ready) txr_cnt++;
    if (done) done_cnt++;
    if (rx_valid) begin
      if (rx_n < 16) rx_log[rx_n] = rx_data;
      rx_n++;
    end
    if (!prev_cs && CS_n_0) cs_rise_cnt++;
    if (prev_cs && !CS_n_0) begin
      slave_sr = resp[0];
      resp_idx = 1; fbits = 0; rbits = 0; mosi_n = 0;
    end else if (!CS_n_0) begin
      if (!prev_sclk && SCLK_0) begin
        mosi_sr = {mosi_sr[6:0], MOSI_0};
        rbits++;
        if (rbits == 8) begin
          if (mosi_n < 16) mosi_log[mosi_n] = mosi_sr;
          mosi_n++;
          rbits = 0;
        end
      end
      if (prev_sclk && !SCLK_0) begin
        fbits++;
        if (fbits == 8) begin
          slave_sr = (resp_idx < 8) ? resp[resp_idx] : 8'hFF;
          resp_idx++;
          fbits = 0;
        end else begin
          slave_sr = {slave_sr[6:0], 1'b0};
        end
      end
    end
    prev_cs   = CS_n_0;
    prev_sclk = SCLK_0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    logic seen;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk); cyc++; seen = done;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_tx_ready(input string tag, input int budget);
    logic seen;
    int n;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk); n++; seen = tx_ready;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, b_rise, b_txr, b_done, b_rx, b_cs, stall_bad;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;

    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_ctrl", {24'd0, CS_n_0, SCLK_0, MOSI_0, busy, done, tx_ready, rx_valid, timeout_err}, 32'h80);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_status", status_byte, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: write 0x0A to register 0x01
    resp[0] = 8'h25; resp[1] = 8'h5C;
    header = 8'h01; ext_en = 1'b0; len = 8'd1; tx_data = 8'h0A; tx_valid = 1'b1;
    b_txr = txr_cnt; b_done = done_cnt; b_rx = rx_n; b_cs = cs_rise_cnt;
    pulse_start();
    check("t1_busy", busy, 1'b1);
    wait_done("t1_done_seen", 400, cyc);
    check("t1_latency", cyc, 136);
    check("t1_busy_at_done", busy, 1'b0);
    check("t1_cs_high_at_done", CS_n_0, 1'b1);
    @(negedge clk);
    check("t1_done_once", done_cnt - b_done, 1);
    check("t1_cs_single_rise", cs_rise_cnt - b_cs, 1);
    check("t1_mosi_count", mosi_n, 2);
    check("t1_mosi0", mosi_log[0], 8'h01);
    check("t1_mosi1", mosi_log[1], 8'h0A);
    check("t1_tx_ready", txr_cnt - b_txr, 1);
    check("t1_status", status_byte, 8'h25);
    check("t1_rx_count", rx_n - b_rx, 1);
    check("t1_rx_data", rx_data, 8'h5C);

    // Test 2: extended burst read of three bytes
    resp[0] = 8'h25; resp[1] = 8'hA5; resp[2] = 8'h11; resp[3] = 8'h22; resp[4] = 8'h33;
    header = 8'hEF; ext_en = 1'b1; ext_addr = 8'h8F; len = 8'd3; tx_valid = 1'b1; tx_data = 8'hFF;
    b_txr = txr_cnt; b_rx = rx_n;
    pulse_start();
    wait_done("t2_done_seen", 800, cyc);
    check("t2_latency", cyc, 328);
    check("t2_mosi_count", mosi_n, 5);
    check("t2_mosi_hdr", mosi_log[0], 8'hEF);
    check("t2_mosi_ext", mosi_log[1], 8'h8F);
    check("t2_mosi_d0", mosi_log[2], 8'h00);
    check("t2_mosi_d1", mosi_log[3], 8'h00);
    check("t2_mosi_d2", mosi_log[4], 8'h00);
    check("t2_rx_count", rx_n - b_rx, 3);
    check("t2_rx0", rx_log[b_rx], 8'h11);
    check("t2_rx1", rx_log[b_rx + 1], 8'h22);
    check("t2_rx2", rx_log[b_rx + 2], 8'h33);
    check("t2_no_tx_ready", txr_cnt - b_txr, 0);
    check("t2_status", status_byte, 8'h25);

    // Test 3: command strobe, no data bytes
    @(negedge clk);
    resp[0] = 8'h1A;
    header = 8'h30; ext_en = 1'b0; len = 8'd0; tx_valid = 1'b1;
    b_txr = txr_cnt; b_rx = rx_n; b_rise = sclk_rises;
    pulse_start();
    wait_done("t3_done_seen", 300, cyc);
    check("t3_latency", cyc, 72);
    check("t3_sclk_rises", sclk_rises - b_rise, 8);
    check("t3_no_tx_ready", txr_cnt - b_txr, 0);
    check("t3_no_rx_valid", rx_n - b_rx, 0);
    check("t3_mosi", mosi_log[0], 8'h30);
    check("t3_status", status_byte, 8'h1A);

    // Test 4: chip never ready -> timeout
    @(negedge clk);
    miso_force_high = 1'b1;
    header = 8'h01; len = 8'd1; tx_valid = 1'b1;
    b_txr = txr_cnt; b_rise = sclk_rises; b_done = done_cnt;
    pulse_start();
    wait_done("t4_done_seen", 100, cyc);
    check("t4_latency", cyc, 19);
    check("t4_timeout_err", timeout_err, 1'b1);
    check("t4_cs_high", CS_n_0, 1'b1);
    check("t4_no_sclk", sclk_rises - b_rise, 0);
    check("t4_no_tx_ready", txr_cnt - b_txr, 0);
    repeat (3) @(negedge clk);
    check("t4_sticky", timeout_err, 1'b1);
    check("t4_done_once", done_cnt - b_done, 1);
    miso_force_high = 1'b0;

    // Test 5: write burst with a 50-cycle stall before the second data byte
    resp[0] = 8'h25;
    header = 8'h42; len = 8'd2; tx_data = 8'hC3; tx_valid = 1'b1;
    b_txr = txr_cnt; b_done = done_cnt;
    pulse_start();
    @(negedge clk);
    check("t5_timeout_cleared", timeout_err, 1'b0);
    wait_tx_ready("t5_first_tx_ready", 200);
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'h5A;
    repeat (63) @(negedge clk);
    b_rise = sclk_rises; stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (SCLK_0 !== 1'b0 || CS_n_0 !== 1'b0 || busy !== 1'b1) stall_bad++;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
    end
    check("t5_stall_lines", stall_bad, 0);
    check("t5_stall_no_sclk", sclk_rises - b_rise, 0);
    check("t5_stall_tx_ready", txr_cnt - b_txr, 1);
    @(posedge clk); #1 tx_valid = 1'b1;
    wait_tx_ready("t5_second_tx_ready", 20);
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_done("t5_done_seen", 500, cyc);
    repeat (4) @(negedge clk);
    check("t5_idle_after", busy, 1'b0);
    check("t5_done_once", done_cnt - b_done, 1);
    check("t5_tx_ready", txr_cnt - b_txr, 2);
    check("t5_mosi_count", mosi_n, 3);
    check("t5_mosi_hdr", mosi_log[0], 8'h42);
    check("t5_mosi_d0", mosi_log[1], 8'hC3);
    check("t5_mosi_d1", mosi_log[2], 8'h5A);

    // Test 6: reset in the middle of the header slot
    header = 8'h01; len = 8'd1; tx_data = 8'h77; tx_valid = 1'b1;
    b_done = done_cnt;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t6_sclk_high_before", SCLK_0, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_cs_reset", CS_n_0, 1'b1);
    check("t6_sclk_reset", SCLK_0, 1'b0);
    check("t6_busy_reset", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", done_cnt - b_done, 0);
    resp[0] = 8'h25; resp[1] = 8'h00;
    header = 8'h05; tx_data = 8'h99; tx_valid = 1'b1;
    pulse_start();
    wait_done("t6_done_seen", 400, cyc);
    check("t6_latency", cyc, 136);
    check("t6_mosi_hdr", mosi_log[0], 8'h05);
    check("t6_mosi_d0", mosi_log[1], 8'h99);
    check("t6_status", status_byte, 8'h25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
